// File: rtl/nrzi_toggle_rx_pkg.sv
// Shared definitions for the toggle-encoded serial link receiver.
// Holds the FSM state encodings and the default link parameters, so the
// transmitter side can import the same package and stay in agreement.
package nrzi_toggle_rx_pkg;

    localparam int         DEF_DATA_W    = 8;
    localparam logic [7:0] DEF_SYNC_WORD = 8'hD5;
    localparam int         DEF_STUFF_LEN = 6;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } rx_state_t;

endpackage

// File: rtl/nrzi_toggle_rx_if.sv
// Output side of the receiver: the valid/ready word channel plus the
// frame status strobes and the sticky overrun flag.
interface nrzi_toggle_rx_if
    import nrzi_toggle_rx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              frame_start;
    logic              frame_end;
    logic              err_stuff;
    logic              overrun;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready,
        output frame_start,
        output frame_end,
        output err_stuff,
        output overrun
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready,
        input  frame_start,
        input  frame_end,
        input  err_stuff,
        input  overrun
    );
endinterface

// File: rtl/nrzi_bit_destuff.sv
// Bit recovery and destuffing for the toggle-encoded line.
// A line transition is a '1', no transition is a '0'. After STUFF_LEN zeros
// the transmitter inserts a '1' which is swallowed here; a further '0' in that
// position is reported as a stuff violation (used as the end-of-frame marker).
module nrzi_bit_destuff
    import nrzi_toggle_rx_pkg::*;
#(
    parameter int STUFF_LEN = DEF_STUFF_LEN
)(
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic line_in,
    output logic bit_vld,
    output logic bit_val,
    output logic stuff_viol
);

    logic       line_prev;
    logic [3:0] zero_cnt;
    logic       raw;
    logic       at_limit;

    assign raw        = line_in ^ line_prev;
    assign at_limit   = (zero_cnt == 4'(STUFF_LEN));
    assign bit_vld    = bit_en && !at_limit;
    assign bit_val    = raw;
    assign stuff_viol = bit_en && at_limit && !raw;

    // Track the previous line level and the run of zeros, saturating at the stuff limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_prev <= 1'b0;
            zero_cnt  <= 4'd0;
        end else if (bit_en) begin
            line_prev <= line_in;
            if (raw) begin
                zero_cnt <= 4'd0;
            end else if (!at_limit) begin
                zero_cnt <= zero_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/nrzi_toggle_rx.sv
// Receive end of the toggle-encoded serial link.
// Hunts for the sync word on the destuffed bit stream, then assembles
// LSB-first words into a single output register with valid/ready handshake.
// A stuff violation on a word boundary ends the frame; elsewhere it aborts it.
module nrzi_toggle_rx
    import nrzi_toggle_rx_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(DEF_SYNC_WORD),
    parameter int                STUFF_LEN = DEF_STUFF_LEN
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_en,
    input  logic                line_in,
    nrzi_toggle_rx_if.master    rx
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic              bit_vld;
    logic              bit_val;
    logic              stuff_viol;

    rx_state_t         state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] hunt_sr;
    logic [DATA_W-1:0] data_sr;
    logic [DATA_W-1:0] hunt_next;
    logic [DATA_W-1:0] word_next;

    nrzi_bit_destuff #(
        .STUFF_LEN (STUFF_LEN)
    ) u_destuff (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .line_in    (line_in),
        .bit_vld    (bit_vld),
        .bit_val    (bit_val),
        .stuff_viol (stuff_viol)
    );

    assign hunt_next = {bit_val, hunt_sr[DATA_W-1:1]};
    assign word_next = {bit_val, data_sr[DATA_W-1:1]};

    // Frame FSM, shift registers and the held output word with its status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_HUNT;
            bit_cnt        <= '0;
            hunt_sr        <= '0;
            data_sr        <= '0;
            rx.out_data    <= '0;
            rx.out_valid   <= 1'b0;
            rx.frame_start <= 1'b0;
            rx.frame_end   <= 1'b0;
            rx.err_stuff   <= 1'b0;
            rx.overrun     <= 1'b0;
        end else begin
            rx.frame_start <= 1'b0;
            rx.frame_end   <= 1'b0;
            rx.err_stuff   <= 1'b0;

            if (rx.out_valid && rx.out_ready) begin
                rx.out_valid <= 1'b0;
            end

            case (state)
                ST_HUNT: begin
                    if (bit_vld) begin
                        if (hunt_next == SYNC_WORD) begin
                            rx.frame_start <= 1'b1;
                            bit_cnt        <= '0;
                            data_sr        <= '0;
                            hunt_sr        <= '0;
                            state          <= ST_DATA;
                        end else begin
                            hunt_sr <= hunt_next;
                        end
                    end
                end

                ST_DATA: begin
                    if (stuff_viol) begin
                        if (bit_cnt == '0) begin
                            rx.frame_end <= 1'b1;
                        end else begin
                            rx.err_stuff <= 1'b1;
                        end
                        bit_cnt <= '0;
                        data_sr <= '0;
                        state   <= ST_HUNT;
                    end else if (bit_vld) begin
                        data_sr <= word_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (!rx.out_valid || rx.out_ready) begin
                                rx.out_data  <= word_next;
                                rx.out_valid <= 1'b1;
                            end else begin
                                rx.overrun <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule
